knn_vote_ctrl: RTL and testbench

- Sequencer for the combinational `distance_sort` network in the KNN system.
- Accepts N (distance, type) pairs over a valid/ready stream and registers them as the sorter's input arrays.
- Waits for the sorter outputs to settle, then counts class votes over the K nearest entries of `type_array_sorted`.
- Reports the majority class with a one-cycle done pulse; sits between the distance-computation stage and the classification output.

---
 rtl/knn_vote_ctrl_pkg.sv | 24 ++
 rtl/distance_sort.sv | 39 +++
 rtl/knn_vote_ctrl.sv | 172 +++++++++++++++++
 tb/tb_knn_vote_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/knn_vote_ctrl_pkg.sv
// Shared types and default sizing for the KNN vote controller and its sorter.
package knn_vote_ctrl_pkg;

    localparam int N_DEF           = 64;
    localparam int B_DEF           = 32;
    localparam int K_DEF           = 5;
    localparam int NUM_CLASSES_DEF = 8;
    localparam int SORT_WAIT_DEF   = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SORT,
        VOTE,
        PICK,
        DONE
    } state_t;

    // Bits needed to index 0..n-1, never less than one so single-entry ranges stay legal.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/distance_sort.sv
// Combinational ascending sort of (distance, type) pairs by distance, using per-entry ranking.
module distance_sort
    import knn_vote_ctrl_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int B = B_DEF
) (
    input  logic [B-1:0] distance_array        [N],
    input  logic [B-1:0] type_array            [N],
    output logic [B-1:0] distance_array_sorted [N],
    output logic [B-1:0] type_array_sorted     [N]
);

    localparam int RW = idx_w(N);

    logic [RW-1:0] rank;

    // Equal distances are ranked by position, so every entry gets a unique slot.
    always_comb begin
        // NOTE: every output gets a default before the loops so no latch is inferred.
        rank = '0;
        for (int i = 0; i < N; i++) begin
            distance_array_sorted[i] = '0;
            type_array_sorted[i]     = '0;
        end
        for (int i = 0; i < N; i++) begin
            rank = '0;
            for (int j = 0; j < N; j++) begin
                if ((distance_array[j] < distance_array[i]) ||
                    ((distance_array[j] == distance_array[i]) && (j < i))) begin
                    rank = rank + 1'b1;
                end
            end
            distance_array_sorted[rank] = distance_array[i];
            type_array_sorted[rank]     = type_array[i];
        end
    end

endmodule

// File: rtl/knn_vote_ctrl.sv
// Loads N (distance, type) pairs, lets the sorter settle, votes over the K nearest
// labels and reports the majority class with a one-cycle done pulse.
module knn_vote_ctrl
    import knn_vote_ctrl_pkg::*;
#(
    parameter int N           = N_DEF,
    parameter int B           = B_DEF,
    parameter int K           = K_DEF,
    parameter int NUM_CLASSES = NUM_CLASSES_DEF,
    parameter int SORT_WAIT   = SORT_WAIT_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [B-1:0]           in_distance,
    input  logic [B-1:0]           in_type,
    output logic                   busy,
    output logic                   done,
    output logic [B-1:0]           result_type,
    output logic [$clog2(K+1)-1:0] result_votes
);

    localparam int IW = idx_w(N);
    localparam int KW = idx_w(K);
    localparam int CW = idx_w(NUM_CLASSES);
    localparam int SW = idx_w(SORT_WAIT);
    localparam int VW = $clog2(K + 1);

    localparam logic [IW-1:0] LAST_LOAD  = IW'(N - 1);
    localparam logic [KW-1:0] LAST_VOTE  = KW'(K - 1);
    localparam logic [CW-1:0] LAST_CLASS = CW'(NUM_CLASSES - 1);
    localparam logic [SW-1:0] LAST_WAIT  = SW'(SORT_WAIT - 1);
    localparam logic [B-1:0]  NC_LIMIT   = B'(NUM_CLASSES);

    state_t        state_q;
    logic [IW-1:0] load_idx_q;
    logic [SW-1:0] wait_q;
    logic [KW-1:0] vote_idx_q;
    logic [CW-1:0] pick_idx_q;
    logic [VW-1:0] votes_q [NUM_CLASSES];
    logic [CW-1:0] best_class_q;
    logic [VW-1:0] best_votes_q;
    logic [B-1:0]  dist_q  [N];
    logic [B-1:0]  type_q  [N];
    logic          in_ready_q;
    logic          busy_q;
    logic          done_q;
    logic [B-1:0]  result_type_q;
    logic [VW-1:0] result_votes_q;

    logic [B-1:0]  type_sorted       [N];
    logic [B-1:0]  unused_sorted_dist [N];

    distance_sort #(
        .N (N),
        .B (B)
    ) u_sort (
        .distance_array        (dist_q),
        .type_array            (type_q),
        .distance_array_sorted (unused_sorted_dist),
        .type_array_sorted     (type_sorted)
    );

    logic [B-1:0]  vote_type;
    logic          vote_hit;
    logic [VW-1:0] pick_votes;
    logic          pick_wins;
    logic [CW-1:0] best_class_d;
    logic [VW-1:0] best_votes_d;

    assign vote_type  = type_sorted[vote_idx_q];
    assign vote_hit   = (vote_type < NC_LIMIT);
    assign pick_votes = votes_q[pick_idx_q];
    // Strictly-greater replacement keeps the lowest class index on ties.
    assign pick_wins    = (pick_votes > best_votes_q);
    assign best_class_d = pick_wins ? pick_idx_q : best_class_q;
    assign best_votes_d = pick_wins ? pick_votes : best_votes_q;

    // NOTE: all state, including the pair arrays, updates with <= so every read sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            load_idx_q     <= '0;
            wait_q         <= '0;
            vote_idx_q     <= '0;
            pick_idx_q     <= '0;
            best_class_q   <= '0;
            best_votes_q   <= '0;
            in_ready_q     <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            result_type_q  <= '0;
            result_votes_q <= '0;
            for (int c = 0; c < NUM_CLASSES; c++) votes_q[c] <= '0;
            // NOTE: the pair arrays are reset too, so the sorter never sees stale data after reset.
            for (int i = 0; i < N; i++) begin
                dist_q[i] <= '0;
                type_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= LOAD;
                        load_idx_q <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        for (int c = 0; c < NUM_CLASSES; c++) votes_q[c] <= '0;
                    end
                end
                LOAD: begin
                    if (in_valid && in_ready_q) begin
                        dist_q[load_idx_q] <= in_distance;
                        type_q[load_idx_q] <= in_type;
                        load_idx_q         <= load_idx_q + 1'b1;
                        if (load_idx_q == LAST_LOAD) begin
                            state_q    <= SORT;
                            wait_q     <= '0;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                SORT: begin
                    if (wait_q == LAST_WAIT) begin
                        state_q    <= VOTE;
                        vote_idx_q <= '0;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                VOTE: begin
                    if (vote_hit) begin
                        votes_q[vote_type[CW-1:0]] <= votes_q[vote_type[CW-1:0]] + 1'b1;
                    end
                    vote_idx_q <= vote_idx_q + 1'b1;
                    if (vote_idx_q == LAST_VOTE) begin
                        state_q      <= PICK;
                        pick_idx_q   <= '0;
                        best_class_q <= '0;
                        best_votes_q <= '0;
                    end
                end
                PICK: begin
                    best_class_q <= best_class_d;
                    best_votes_q <= best_votes_d;
                    pick_idx_q   <= pick_idx_q + 1'b1;
                    if (pick_idx_q == LAST_CLASS) begin
                        state_q        <= DONE;
                        done_q         <= 1'b1;
                        result_type_q  <= B'(best_class_d);
                        result_votes_q <= best_votes_d;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign result_type  = result_type_q;
    assign result_votes = result_votes_q;

endmodule

// File: tb/tb_knn_vote_ctrl.sv
// Scenario bench for knn_vote_ctrl with a sort-and-count reference model.
module tb_knn_vote_ctrl;

    localparam int N           = 64;
    localparam int B           = 32;
    localparam int K           = 5;
    localparam int NUM_CLASSES = 8;
    localparam int SORT_WAIT   = 2;
    localparam int VW          = $clog2(K + 1);
    localparam int LAT         = SORT_WAIT + K + NUM_CLASSES + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [B-1:0]  in_distance = '0;
    logic [B-1:0]  in_type = '0;
    logic          busy;
    logic          done;
    logic [B-1:0]  result_type;
    logic [VW-1:0] result_votes;

    int n_cmp = 0;
    int n_bad = 0;

    logic [B-1:0] d_arr [N];
    logic [B-1:0] t_arr [N];

    always #5 clk = ~clk;

    knn_vote_ctrl #(
        .N           (N),
        .B           (B),
        .K           (K),
        .NUM_CLASSES (NUM_CLASSES),
        .SORT_WAIT   (SORT_WAIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_distance  (in_distance),
        .in_type      (in_type),
        .busy         (busy),
        .done         (done),
        .result_type  (result_type),
        .result_votes (result_votes)
    );

    // Reference: take the K smallest distances, count in-range labels, first maximum wins.
    function automatic void model(output logic [B-1:0] et, output logic [VW-1:0] ev);
        bit used [N];
        int votes [NUM_CLASSES];
        int best;
        for (int i = 0; i < N; i++) used[i] = 1'b0;
        for (int c = 0; c < NUM_CLASSES; c++) votes[c] = 0;
        for (int k = 0; k < K; k++) begin
            best = -1;
            for (int i = 0; i < N; i++)
                if (!used[i] && (best < 0 || d_arr[i] < d_arr[best])) best = i;
            used[best] = 1'b1;
            if (t_arr[best] < NUM_CLASSES) votes[t_arr[best]]++;
        end
        best = 0;
        for (int c = 1; c < NUM_CLASSES; c++) if (votes[c] > votes[best]) best = c;
        et = B'(best);
        ev = VW'(votes[best]);
    endfunction

    // Drives one full query and reports what was observed; all comparisons live in the tests.
    task automatic run_query(input bit toggle, input bit pulse_start,
                             output int lat, output int pulses, output bit timeout,
                             output logic ready_after, output logic busy_in_done,
                             output logic busy_after, output logic [B-1:0] rt,
                             output logic [VW-1:0] rv);
        int  hs;
        int  cyc;
        bit  v;
        bit  fire;
        hs = 0; cyc = 0; lat = -1; pulses = 0;
        busy_in_done = 1'bx; busy_after = 1'bx; rt = 'x; rv = 'x;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (hs < N && cyc < 4 * N) begin
            v           = toggle ? (cyc % 2 == 0) : 1'b1;
            in_valid    = v;
            in_distance = d_arr[hs];
            in_type     = t_arr[hs];
            fire        = v && (in_ready === 1'b1);
            @(posedge clk); #1;
            cyc++;
            if (fire) hs++;
        end
        in_valid    = 1'b0;
        timeout     = (hs < N);
        ready_after = in_ready;
        for (int c = 1; c <= 30; c++) begin
            start = pulse_start && (c == 1 || c == 4);
            if (done === 1'b1) begin
                pulses++;
                if (lat < 0) begin
                    lat = c; rt = result_type; rv = result_votes; busy_in_done = busy;
                end
            end
            if (lat > 0 && c == lat + 1) busy_after = busy;
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_cmp++;
        if ({in_ready, busy, done} !== 3'b000) begin
            n_bad++; $display("FAIL reset_flags: got %b expected 000", {in_ready, busy, done});
        end
        n_cmp++;
        if (result_type !== '0 || result_votes !== '0) begin
            n_bad++; $display("FAIL reset_result: got %0d/%0d expected 0/0", result_type, result_votes);
        end
    endtask

    // Shared comparison body is spelled out per scenario; this task only fills the arrays.
    task automatic fill_seq(input int mode);
        for (int i = 0; i < N; i++) begin
            case (mode)
                1: begin d_arr[i] = B'(i);       t_arr[i] = B'(i % 3); end
                2: begin d_arr[i] = B'(100 - i); t_arr[i] = (i >= 59) ? 4 : 1; end
                3: begin d_arr[i] = B'($urandom_range(0, 100)); t_arr[i] = 5; end
                default: begin
                    d_arr[i] = B'(i);
                    t_arr[i] = (i < 3) ? 9 : (i < 5) ? 2 : 1;
                end
            endcase
        end
    endtask

    task automatic test_tie_break();
        int lat, pulses; bit to; logic ra, bd, ba; logic [B-1:0] rt, et; logic [VW-1:0] rv, ev;
        fill_seq(1);
        model(et, ev);
        run_query(1'b0, 1'b0, lat, pulses, to, ra, bd, ba, rt, rv);
        n_cmp++; if (to) begin n_bad++; $display("FAIL tie_load_timeout: got timeout expected 64 handshakes"); end
        n_cmp++; if (ra !== 1'b0) begin n_bad++; $display("FAIL tie_ready_after: got %b expected 0", ra); end
        n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL tie_latency: got %0d expected %0d", lat, LAT); end
        n_cmp++; if (rt !== et || rv !== ev || et !== 0 || ev !== 2) begin
            n_bad++; $display("FAIL tie_result: got %0d/%0d expected %0d/%0d", rt, rv, et, ev);
        end
    endtask

    task automatic test_nearest();
        int lat, pulses; bit to; logic ra, bd, ba; logic [B-1:0] rt, et; logic [VW-1:0] rv, ev;
        fill_seq(2);
        model(et, ev);
        run_query(1'b0, 1'b0, lat, pulses, to, ra, bd, ba, rt, rv);
        n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL nearest_latency: got %0d expected %0d", lat, LAT); end
        n_cmp++; if (rt !== et || rv !== ev || et !== 4 || ev !== 5) begin
            n_bad++; $display("FAIL nearest_result: got %0d/%0d expected %0d/%0d", rt, rv, et, ev);
        end
    endtask

    task automatic test_gapped_valid();
        int lat, pulses; bit to; logic ra, bd, ba; logic [B-1:0] rt, et; logic [VW-1:0] rv, ev;
        fill_seq(3);
        model(et, ev);
        run_query(1'b1, 1'b0, lat, pulses, to, ra, bd, ba, rt, rv);
        n_cmp++; if (to) begin n_bad++; $display("FAIL gap_load_timeout: got timeout expected 64 handshakes"); end
        n_cmp++; if (ra !== 1'b0) begin n_bad++; $display("FAIL gap_ready_after: got %b expected 0", ra); end
        n_cmp++; if (rt !== et || rv !== ev || et !== 5 || ev !== 5) begin
            n_bad++; $display("FAIL gap_result: got %0d/%0d expected %0d/%0d", rt, rv, et, ev);
        end
    endtask

    task automatic test_out_of_range();
        int lat, pulses; bit to; logic ra, bd, ba; logic [B-1:0] rt, et; logic [VW-1:0] rv, ev;
        fill_seq(4);
        model(et, ev);
        run_query(1'b0, 1'b0, lat, pulses, to, ra, bd, ba, rt, rv);
        n_cmp++; if (rt !== et || rv !== ev || et !== 2 || ev !== 2) begin
            n_bad++; $display("FAIL oor_result: got %0d/%0d expected %0d/%0d", rt, rv, et, ev);
        end
    endtask

    task automatic test_reset_abort();
        int lat, pulses, seen; bit to; logic ra, bd, ba; logic [B-1:0] rt, et; logic [VW-1:0] rv, ev;
        fill_seq(1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_distance = 32'd500 + B'(i); in_type = 32'd7;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            n_bad++; $display("FAIL abort_flags: got busy=%b ready=%b expected 0/0", busy, in_ready);
        end
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            if (done === 1'b1) seen++;
            @(posedge clk); #1;
        end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL abort_done: got %0d pulses expected 0", seen); end
        model(et, ev);
        run_query(1'b0, 1'b0, lat, pulses, to, ra, bd, ba, rt, rv);
        n_cmp++; if (to || lat !== LAT) begin
            n_bad++; $display("FAIL abort_reload: got timeout=%0d lat=%0d expected 0/%0d", to, lat, LAT);
        end
        n_cmp++; if (rt !== et || rv !== ev) begin
            n_bad++; $display("FAIL abort_result: got %0d/%0d expected %0d/%0d", rt, rv, et, ev);
        end
    endtask

    task automatic test_start_ignored();
        int lat, pulses; bit to; logic ra, bd, ba; logic [B-1:0] rt, et; logic [VW-1:0] rv, ev;
        fill_seq(2);
        model(et, ev);
        run_query(1'b0, 1'b1, lat, pulses, to, ra, bd, ba, rt, rv);
        n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL ign_pulses: got %0d expected 1", pulses); end
        n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL ign_latency: got %0d expected %0d", lat, LAT); end
        n_cmp++; if (bd !== 1'b1 || ba !== 1'b0) begin
            n_bad++; $display("FAIL ign_busy: got done=%b after=%b expected 1/0", bd, ba);
        end
        n_cmp++; if (busy !== 1'b0 || result_type !== et || result_votes !== ev) begin
            n_bad++; $display("FAIL ign_hold: got busy=%b %0d/%0d expected 0 %0d/%0d",
                              busy, result_type, result_votes, et, ev);
        end
    endtask

    task automatic test_random();
        int lat, pulses, j; bit to; logic ra, bd, ba; logic [B-1:0] rt, et, tmp; logic [VW-1:0] rv, ev;
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < N; i++) begin
                d_arr[i] = B'(i * 1000 + $urandom_range(0, 999));
                t_arr[i] = B'($urandom_range(0, 9));
            end
            for (int i = N - 1; i > 0; i--) begin
                j = $urandom_range(0, i);
                tmp = d_arr[i]; d_arr[i] = d_arr[j]; d_arr[j] = tmp;
            end
            model(et, ev);
            run_query(it[0], 1'b0, lat, pulses, to, ra, bd, ba, rt, rv);
            n_cmp++; if (to || lat !== LAT || pulses !== 1) begin
                n_bad++; $display("FAIL rand%0d_timing: got to=%0d lat=%0d pulses=%0d expected 0/%0d/1",
                                  it, to, lat, pulses, LAT);
            end
            n_cmp++; if (rt !== et || rv !== ev) begin
                n_bad++; $display("FAIL rand%0d_result: got %0d/%0d expected %0d/%0d", it, rt, rv, et, ev);
            end
        end
    endtask

    initial begin
        test_reset();
        test_tie_break();
        test_nearest();
        test_gapped_valid();
        test_out_of_range();
        test_reset_abort();
        test_start_ignored();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
